// File: rtl/thread_state_mgr.sv
// Per-thread state array of an md5crypt CPU group. CPU, loader and unloader writes are
// arbitrated into one write stage. Two async read ports. Post-reset sweep clears all entries.
module thread_state_mgr #(
   parameter int N_CORES          = -1,
   parameter int N_THREADS        = 4 * N_CORES,
   parameter int N_THREADS_MSB    = (N_THREADS > 1) ? $clog2(N_THREADS) - 1 : 0,
   localparam int THREAD_STATE_MSB = 1
) (
   input  logic                        CLK,
   input  logic                        RESET_N,
   input  logic [N_THREADS_MSB:0]      ts_rd_num,
   output logic [THREAD_STATE_MSB:0]   ts_rd,
   input  logic [N_THREADS_MSB:0]      ts_rd_num2,
   output logic [THREAD_STATE_MSB:0]   ts_rd2,
   input  logic                        ts_wr_en_cpu,
   input  logic [N_THREADS_MSB:0]      ts_wr_num_cpu,
   input  logic [THREAD_STATE_MSB:0]   ts_wr_cpu,
   input  logic                        ts_wr_en_ld,
   input  logic [N_THREADS_MSB:0]      ts_wr_num_ld,
   input  logic [THREAD_STATE_MSB:0]   ts_wr_ld,
   output logic                        ts_wr_rdy_ld,
   input  logic                        ts_wr_en_ul,
   input  logic [N_THREADS_MSB:0]      ts_wr_num_ul,
   input  logic [THREAD_STATE_MSB:0]   ts_wr_ul,
   output logic                        ts_wr_rdy_ul,
   output logic                        init_done
);

   localparam int unsigned TS_W  = THREAD_STATE_MSB + 1;
   localparam int unsigned NUM_W = N_THREADS_MSB + 1;
   localparam int unsigned CNT_W = NUM_W + 1;
   // Clamped so an un-overridden elaboration still yields a legal array size.
   localparam int unsigned DEPTH = (N_THREADS > 0) ? N_THREADS : 1;
   localparam logic [TS_W-1:0] THREAD_STATE_NONE = TS_W'(0);

   logic [TS_W-1:0]  mem_q [DEPTH];

   logic             hold_ld_vld_q, hold_ld_vld_d;
   logic [NUM_W-1:0] hold_ld_num_q, hold_ld_num_d;
   logic [TS_W-1:0]  hold_ld_st_q,  hold_ld_st_d;
   logic             hold_ul_vld_q, hold_ul_vld_d;
   logic [NUM_W-1:0] hold_ul_num_q, hold_ul_num_d;
   logic [TS_W-1:0]  hold_ul_st_q,  hold_ul_st_d;
   logic             ws_en_q,  ws_en_d;
   logic [NUM_W-1:0] ws_num_q, ws_num_d;
   logic [TS_W-1:0]  ws_st_q,  ws_st_d;
   logic [CNT_W-1:0] sweep_cnt_q, sweep_cnt_d;
   logic             init_done_q, init_done_d;
   logic             rdy_ld_q, rdy_ld_d;
   logic             rdy_ul_q, rdy_ul_d;

   // Sweep overrides everything; afterwards CPU > loader holding > unloader holding.
   always_comb begin
      hold_ld_vld_d = hold_ld_vld_q;
      hold_ld_num_d = hold_ld_num_q;
      hold_ld_st_d  = hold_ld_st_q;
      hold_ul_vld_d = hold_ul_vld_q;
      hold_ul_num_d = hold_ul_num_q;
      hold_ul_st_d  = hold_ul_st_q;
      ws_en_d       = 1'b0;
      ws_num_d      = ws_num_q;
      ws_st_d       = ws_st_q;
      sweep_cnt_d   = sweep_cnt_q;
      init_done_d   = init_done_q;

      if (!init_done_q) begin
         if (sweep_cnt_q < CNT_W'(DEPTH)) begin
            ws_en_d     = 1'b1;
            ws_num_d    = sweep_cnt_q[NUM_W-1:0];
            ws_st_d     = THREAD_STATE_NONE;
            sweep_cnt_d = sweep_cnt_q + CNT_W'(1);
         end else begin
            init_done_d = 1'b1;
         end
      end else if (ts_wr_en_cpu) begin
         ws_en_d  = 1'b1;
         ws_num_d = ts_wr_num_cpu;
         ws_st_d  = ts_wr_cpu;
      end else if (hold_ld_vld_q) begin
         ws_en_d       = 1'b1;
         ws_num_d      = hold_ld_num_q;
         ws_st_d       = hold_ld_st_q;
         hold_ld_vld_d = 1'b0;
      end else if (hold_ul_vld_q) begin
         ws_en_d       = 1'b1;
         ws_num_d      = hold_ul_num_q;
         ws_st_d       = hold_ul_st_q;
         hold_ul_vld_d = 1'b0;
      end

      // Accept only into an empty holding register, so accept and win never coincide.
      if (ts_wr_en_ld && rdy_ld_q) begin
         hold_ld_vld_d = 1'b1;
         hold_ld_num_d = ts_wr_num_ld;
         hold_ld_st_d  = ts_wr_ld;
      end
      if (ts_wr_en_ul && rdy_ul_q) begin
         hold_ul_vld_d = 1'b1;
         hold_ul_num_d = ts_wr_num_ul;
         hold_ul_st_d  = ts_wr_ul;
      end

      rdy_ld_d = !hold_ld_vld_d && init_done_d;
      rdy_ul_d = !hold_ul_vld_d && init_done_d;
   end

   always_ff @(posedge CLK) begin
      if (!RESET_N) begin
         hold_ld_vld_q <= 1'b0;
         hold_ld_num_q <= '0;
         hold_ld_st_q  <= '0;
         hold_ul_vld_q <= 1'b0;
         hold_ul_num_q <= '0;
         hold_ul_st_q  <= '0;
         ws_en_q       <= 1'b0;
         ws_num_q      <= '0;
         ws_st_q       <= '0;
         sweep_cnt_q   <= '0;
         init_done_q   <= 1'b0;
         rdy_ld_q      <= 1'b0;
         rdy_ul_q      <= 1'b0;
      end else begin
         hold_ld_vld_q <= hold_ld_vld_d;
         hold_ld_num_q <= hold_ld_num_d;
         hold_ld_st_q  <= hold_ld_st_d;
         hold_ul_vld_q <= hold_ul_vld_d;
         hold_ul_num_q <= hold_ul_num_d;
         hold_ul_st_q  <= hold_ul_st_d;
         ws_en_q       <= ws_en_d;
         ws_num_q      <= ws_num_d;
         ws_st_q       <= ws_st_d;
         sweep_cnt_q   <= sweep_cnt_d;
         init_done_q   <= init_done_d;
         rdy_ld_q      <= rdy_ld_d;
         rdy_ul_q      <= rdy_ul_d;
      end
   end

   // Distributed RAM: single write port fed by the write stage, no reset.
   always_ff @(posedge CLK) begin
      if (ws_en_q) begin
         mem_q[ws_num_q] <= ws_st_q;
      end
   end

   assign ts_rd        = mem_q[ts_rd_num];
   assign ts_rd2       = mem_q[ts_rd_num2];
   assign ts_wr_rdy_ld = rdy_ld_q;
   assign ts_wr_rdy_ul = rdy_ul_q;
   assign init_done    = init_done_q;

endmodule

// File: tb/tb_thread_state_mgr.sv
// Scoreboard bench for thread_state_mgr (N_CORES=1): stimulus pushes cycle-tagged
// expectations, a negedge monitor pops and compares those due in the current cycle.
module tb_thread_state_mgr;

   localparam logic [1:0] S_NONE   = 2'd0;
   localparam logic [1:0] S_WR_RDY = 2'd1;
   localparam logic [1:0] S_RD_RDY = 2'd2;
   localparam logic [1:0] S_BUSY   = 2'd3;
   localparam int K_RD = 0, K_INIT = 1, K_RDY_LD = 2, K_RDY_UL = 3;

   logic       CLK = 1'b0;
   logic       RESET_N = 1'b0;
   logic [1:0] ts_rd_num = '0, ts_rd_num2 = '0;
   logic [1:0] ts_rd, ts_rd2;
   logic       ts_wr_en_cpu = 1'b0, ts_wr_en_ld = 1'b0, ts_wr_en_ul = 1'b0;
   logic [1:0] ts_wr_num_cpu = '0, ts_wr_num_ld = '0, ts_wr_num_ul = '0;
   logic [1:0] ts_wr_cpu = '0, ts_wr_ld = '0, ts_wr_ul = '0;
   logic       ts_wr_rdy_ld, ts_wr_rdy_ul, init_done;

   int cyc = 0;
   int n_vec = 0;
   int n_bad = 0;

   typedef struct {
      int         cyc;
      int         kind;
      int         addr;
      logic [1:0] val;
      string      name;
   } exp_t;
   exp_t sb[$];

   thread_state_mgr #(.N_CORES(1)) dut (
      .CLK(CLK), .RESET_N(RESET_N),
      .ts_rd_num(ts_rd_num), .ts_rd(ts_rd),
      .ts_rd_num2(ts_rd_num2), .ts_rd2(ts_rd2),
      .ts_wr_en_cpu(ts_wr_en_cpu), .ts_wr_num_cpu(ts_wr_num_cpu), .ts_wr_cpu(ts_wr_cpu),
      .ts_wr_en_ld(ts_wr_en_ld), .ts_wr_num_ld(ts_wr_num_ld), .ts_wr_ld(ts_wr_ld),
      .ts_wr_rdy_ld(ts_wr_rdy_ld),
      .ts_wr_en_ul(ts_wr_en_ul), .ts_wr_num_ul(ts_wr_num_ul), .ts_wr_ul(ts_wr_ul),
      .ts_wr_rdy_ul(ts_wr_rdy_ul),
      .init_done(init_done)
   );

   initial forever #10 CLK = ~CLK;
   always @(posedge CLK) cyc <= cyc + 1;

   function automatic void expect_at(input int c, input int k, input int a,
                                     input logic [1:0] v, input string n);
      exp_t e;
      e.cyc = c; e.kind = k; e.addr = a; e.val = v; e.name = n;
      sb.push_back(e);
   endfunction

   function automatic void cmp(input logic [1:0] got, input logic [1:0] exp, input string n);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s cyc=%0d got=%0d expected=%0d", n, cyc, got, exp);
      end
   endfunction

   task automatic check_one(input exp_t e);
      case (e.kind)
         K_RD: begin
            ts_rd_num  = 2'(e.addr);
            ts_rd_num2 = 2'(e.addr);
            #1;
            cmp(ts_rd,  e.val, {e.name, "/ts_rd"});
            cmp(ts_rd2, e.val, {e.name, "/ts_rd2"});
         end
         K_INIT:   cmp({1'b0, init_done},    e.val, e.name);
         K_RDY_LD: cmp({1'b0, ts_wr_rdy_ld}, e.val, e.name);
         default:  cmp({1'b0, ts_wr_rdy_ul}, e.val, e.name);
      endcase
   endtask

   // Monitor: compare everything due this cycle, flag anything overdue.
   initial begin : monitor
      exp_t keep[$];
      exp_t e;
      forever begin
         @(negedge CLK);
         keep = {};
         while (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.cyc == cyc) begin
               check_one(e);
            end else if (e.cyc < cyc) begin
               n_vec++; n_bad++;
               $display("FAIL %s overdue: due cyc=%0d now cyc=%0d", e.name, e.cyc, cyc);
            end else begin
               keep.push_back(e);
            end
         end
         sb = keep;
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: bench did not finish, cyc=%0d expected end before 200", cyc);
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic wait_to(input int c);
      while (cyc < c) tick();
   endtask

   logic [1:0] req_num [4] = '{2'd0, 2'd1, 2'd2, 2'd3};
   logic [1:0] req_st  [4] = '{S_BUSY, S_RD_RDY, S_BUSY, S_BUSY};

   initial begin : stimulus
      int c0, a, b, c, d, e, idx;
      bit acc;

      // Reset sweep: 3 reset edges, release, init_done 5 edges later.
      repeat (3) tick();
      c0 = cyc;
      expect_at(c0, K_INIT, 0, 2'd0, "reset_init");
      expect_at(c0, K_RDY_LD, 0, 2'd0, "reset_rdy_ld");
      expect_at(c0, K_RDY_UL, 0, 2'd0, "reset_rdy_ul");
      expect_at(c0 + 4, K_INIT, 0, 2'd0, "sweep_init_low");
      expect_at(c0 + 4, K_RDY_LD, 0, 2'd0, "sweep_rdy_ld_low");
      expect_at(c0 + 5, K_INIT, 0, 2'd1, "sweep_init_high");
      expect_at(c0 + 5, K_RDY_LD, 0, 2'd1, "sweep_rdy_ld_high");
      expect_at(c0 + 5, K_RDY_UL, 0, 2'd1, "sweep_rdy_ul_high");
      for (int t = 0; t < 4; t++) expect_at(c0 + 5, K_RD, t, S_NONE, $sformatf("sweep_t%0d", t));
      RESET_N = 1'b1;
      wait_to(c0 + 5);

      // CPU write: visible 2 edges after the request is driven.
      a = cyc;
      expect_at(a + 1, K_RD, 2, S_NONE, "cpu_t2_old");
      expect_at(a + 2, K_RD, 2, S_WR_RDY, "cpu_t2_new");
      expect_at(a + 2, K_RD, 0, S_NONE, "cpu_t0_old");
      expect_at(a + 3, K_RD, 0, S_RD_RDY, "cpu_t0_new");
      ts_wr_en_cpu = 1'b1; ts_wr_num_cpu = 2'd2; ts_wr_cpu = S_WR_RDY;
      tick();
      ts_wr_num_cpu = 2'd0; ts_wr_cpu = S_RD_RDY;
      tick();
      ts_wr_en_cpu = 1'b0;
      wait_to(a + 3);

      // Priority collision: CPU, then loader holding, then unloader holding.
      b = cyc;
      expect_at(b + 1, K_RDY_LD, 0, 2'd0, "prio_rdy_ld_drop");
      expect_at(b + 1, K_RDY_UL, 0, 2'd0, "prio_rdy_ul_drop");
      expect_at(b + 2, K_RD, 1, S_NONE, "prio_t1_old");
      expect_at(b + 3, K_RD, 1, S_BUSY, "prio_t1_cpu");
      expect_at(b + 3, K_RD, 3, S_NONE, "prio_t3_old");
      expect_at(b + 3, K_RDY_LD, 0, 2'd1, "prio_rdy_ld_rise");
      expect_at(b + 3, K_RDY_UL, 0, 2'd0, "prio_rdy_ul_still_low");
      expect_at(b + 4, K_RD, 3, S_WR_RDY, "prio_t3_ld");
      expect_at(b + 4, K_RD, 0, S_RD_RDY, "prio_t0_old");
      expect_at(b + 4, K_RDY_UL, 0, 2'd1, "prio_rdy_ul_rise");
      expect_at(b + 5, K_RD, 0, S_NONE, "prio_t0_ul");
      ts_wr_en_ld = 1'b1; ts_wr_num_ld = 2'd3; ts_wr_ld = S_WR_RDY;
      ts_wr_en_ul = 1'b1; ts_wr_num_ul = 2'd0; ts_wr_ul = S_NONE;
      tick();
      ts_wr_en_ld = 1'b0; ts_wr_en_ul = 1'b0;
      ts_wr_en_cpu = 1'b1; ts_wr_num_cpu = 2'd1; ts_wr_cpu = S_BUSY;
      tick();
      ts_wr_en_cpu = 1'b0;
      wait_to(b + 5);

      // Same-thread collision: lower-priority loader value is final.
      c = cyc;
      expect_at(c + 1, K_RD, 2, S_WR_RDY, "same_t2_old");
      expect_at(c + 1, K_RDY_LD, 0, 2'd0, "same_rdy_ld_low");
      expect_at(c + 2, K_RD, 2, S_RD_RDY, "same_t2_cpu");
      expect_at(c + 2, K_RDY_LD, 0, 2'd1, "same_rdy_ld_high");
      expect_at(c + 3, K_RD, 2, S_WR_RDY, "same_t2_final");
      ts_wr_en_cpu = 1'b1; ts_wr_num_cpu = 2'd2; ts_wr_cpu = S_RD_RDY;
      ts_wr_en_ld  = 1'b1; ts_wr_num_ld  = 2'd2; ts_wr_ld  = S_WR_RDY;
      tick();
      ts_wr_en_cpu = 1'b0; ts_wr_en_ld = 1'b0;
      wait_to(c + 3);

      // Back-pressure: CPU busy 4 cycles, loader streams 4 requests.
      d = cyc;
      expect_at(d + 2, K_RDY_LD, 0, 2'd0, "bp_rdy_ld_held0");
      expect_at(d + 4, K_RDY_LD, 0, 2'd0, "bp_rdy_ld_held1");
      expect_at(d + 5, K_RDY_LD, 0, 2'd1, "bp_rdy_ld_free0");
      expect_at(d + 6, K_RDY_LD, 0, 2'd0, "bp_rdy_ld_acc1");
      expect_at(d + 7, K_RDY_LD, 0, 2'd1, "bp_rdy_ld_free1");
      expect_at(d + 5, K_RD, 0, S_NONE, "bp_t0_old");
      expect_at(d + 5, K_RD, 3, S_RD_RDY, "bp_t3_cpu");
      expect_at(d + 6, K_RD, 0, S_BUSY, "bp_t0_new");
      expect_at(d + 7, K_RD, 1, S_BUSY, "bp_t1_old");
      expect_at(d + 8, K_RD, 1, S_RD_RDY, "bp_t1_new");
      expect_at(d + 9, K_RD, 2, S_WR_RDY, "bp_t2_old");
      expect_at(d + 10, K_RD, 2, S_BUSY, "bp_t2_new");
      expect_at(d + 11, K_RD, 3, S_RD_RDY, "bp_t3_old");
      expect_at(d + 12, K_RD, 3, S_BUSY, "bp_t3_new");
      expect_at(d + 13, K_RDY_LD, 0, 2'd1, "bp_rdy_ld_idle");
      expect_at(d + 13, K_RD, 0, S_BUSY, "bp_t0_stable");
      idx = 0;
      for (int k = 0; k < 13; k++) begin
         ts_wr_en_cpu = (k < 4); ts_wr_num_cpu = 2'd3; ts_wr_cpu = S_RD_RDY;
         ts_wr_en_ld  = (idx < 4);
         if (idx < 4) begin
            ts_wr_num_ld = req_num[idx];
            ts_wr_ld     = req_st[idx];
         end
         acc = ts_wr_en_ld && ts_wr_rdy_ld;
         tick();
         if (acc) idx++;
      end
      ts_wr_en_cpu = 1'b0; ts_wr_en_ld = 1'b0;
      cmp(2'(idx), 2'(4), "bp_ld_accepts");
      wait_to(d + 13);

      // Mid-operation reset with both holding registers full.
      e = cyc;
      expect_at(e + 1, K_INIT, 0, 2'd1, "mrst_init_before");
      expect_at(e + 1, K_RDY_LD, 0, 2'd0, "mrst_rdy_ld_full");
      expect_at(e + 2, K_INIT, 0, 2'd0, "mrst_init_drop");
      expect_at(e + 2, K_RDY_LD, 0, 2'd0, "mrst_rdy_ld_rst");
      expect_at(e + 2, K_RDY_UL, 0, 2'd0, "mrst_rdy_ul_rst");
      expect_at(e + 6, K_INIT, 0, 2'd0, "mrst_init_low");
      expect_at(e + 7, K_INIT, 0, 2'd1, "mrst_init_high");
      expect_at(e + 7, K_RDY_UL, 0, 2'd1, "mrst_rdy_ul_high");
      for (int t = 0; t < 4; t++) expect_at(e + 7, K_RD, t, S_NONE, $sformatf("mrst_t%0d", t));
      expect_at(e + 10, K_RD, 1, S_NONE, "mrst_ld_dropped");
      expect_at(e + 10, K_RD, 2, S_NONE, "mrst_ul_dropped");
      ts_wr_en_ld = 1'b1; ts_wr_num_ld = 2'd1; ts_wr_ld = S_WR_RDY;
      ts_wr_en_ul = 1'b1; ts_wr_num_ul = 2'd2; ts_wr_ul = S_RD_RDY;
      tick();
      ts_wr_en_ld = 1'b0; ts_wr_en_ul = 1'b0;
      RESET_N = 1'b0;
      tick();
      RESET_N = 1'b1;
      wait_to(e + 12);

      while (sb.size() > 0) begin
         exp_t left;
         left = sb.pop_front();
         n_vec++; n_bad++;
         $display("FAIL %s never checked: due cyc=%0d end cyc=%0d", left.name, left.cyc, cyc);
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/thread_state_mgr.md
# thread_state_mgr

Owns the per-thread state array of an md5crypt CPU group. It is the write side of the thread-state interface whose read side is the CPU's thread selector. It accepts state updates from three writers (CPU, loader, unloader) with fixed priority and per-port holding registers. It serves two asynchronous read ports, one for the thread selector and one for the loader/unloader scan, and clears every entry to `THREAD_STATE_NONE` with a sweep after reset.

## Interface
Parameters:
- N_CORES, -1, number of cores; must be overridden.
- N_THREADS, 4*N_CORES, thread count.
- N_THREADS_MSB, `MSB(N_THREADS-1), thread index MSB.

Ports:
- CLK  in  1  clock.
- RESET_N  in  1  synchronous, active-low reset.
- ts_rd_num  in  N_THREADS_MSB+1  thread selector read address.
- ts_rd  out  THREAD_STATE_MSB+1  state of ts_rd_num; combinational from the array.
- ts_rd_num2  in  N_THREADS_MSB+1  loader/unloader read address.
- ts_rd2  out  THREAD_STATE_MSB+1  state of ts_rd_num2; combinational.
- ts_wr_en_cpu, ts_wr_num_cpu, ts_wr_cpu  in  1 / N_THREADS_MSB+1 / THREAD_STATE_MSB+1  CPU write; never back-pressured.
- ts_wr_en_ld, ts_wr_num_ld, ts_wr_ld  in  same widths  loader write request.
- ts_wr_rdy_ld  out  1  loader holding register empty.
- ts_wr_en_ul, ts_wr_num_ul, ts_wr_ul  in  same widths  unloader write request.
- ts_wr_rdy_ul  out  1  unloader holding register empty.
- init_done  out  1  high once the post-reset sweep has completed.

## Operation
- Storage: N_THREADS x (THREAD_STATE_MSB+1) distributed RAM with one write port and two async read ports.
- State encodings come from md5.vh:
  - NONE: thread empty.
  - WR_RDY: thread runnable by the CPU.
  - RD_RDY: result ready for the unloader.
  - BUSY: thread owned by the loader or unloader.
- Handshakes:
  - Loader and unloader each have a 1-entry holding register.
  - A request is accepted at an edge where ts_wr_en_x=1 and ts_wr_rdy_x=1.
  - ts_wr_rdy_x = holding register empty & init_done, registered.
- Arbitration, evaluated each cycle in priority order:
  1. CPU input.
  2. Loader holding register.
  3. Unloader holding register.
- The winner goes to the write-stage register (wr_en_s, wr_num_s, wr_st_s). A holding register empties on the cycle it wins.
- A CPU write accepted while init_done=0 is dropped.
- Write-stage register commits to the RAM at the next edge.
- No merging: two writes to the same thread in the same cycle both commit, in priority order, so the lower-priority value is final.
- Sweep:
  - While RESET_N=0: sweep_cnt<=0, init_done<=0, holding and write-stage registers cleared.
  - After RESET_N=1: the sweep writes NONE to entry sweep_cnt, one entry per cycle, through the write stage, overriding all ports.
  - init_done<=1 on the edge after entry N_THREADS-1 is issued.
- RESET_N low mid-sweep or mid-operation restarts the sweep from 0. Pending holding-register contents are discarded.
- No illegal-transition checking; writers own protocol correctness.

## Timing
- Reset values:
  - ts_wr_rdy_ld=0, ts_wr_rdy_ul=0, init_done=0.
  - ts_rd/ts_rd2 reflect RAM contents, which are undefined until the sweep writes them.
- CPU write latency: request sampled at edge E0, write-stage loaded at E0, RAM written at E1. ts_rd shows the new value from E1 onward, i.e. 2 cycles after request. This matches the selector's same-thread guard of 2.
- Loader/unloader latency (uncontended): accept at E0, holding register wins at E1, RAM written at E2. Each cycle of contention adds 1.
- ts_wr_rdy_x drops the cycle after acceptance and rises the cycle after its holding register wins. Sustained throughput per low-priority port is therefore 1 write per 2 cycles.
- Sweep takes N_THREADS cycles after reset release; init_done rises at edge N_THREADS+1 after release.
- Read ports: zero latency, no read-during-write forwarding. A read of the address being committed returns the old value until the commit edge.

## Test plan
- Reset sweep, N_CORES=1: hold RESET_N=0 3 cycles, release -> init_done=1 exactly 5 edges later; ts_rd=NONE for threads 0..3; ts_wr_rdy_ld/ul rise with init_done.
- CPU write: ts_wr_cpu=WR_RDY to thread 2 at E0 -> ts_rd (num=2) shows NONE through E0, WR_RDY from E1.
- Priority collision: CPU writes thread 1 BUSY while the loader holding register has thread 3 WR_RDY and the unloader has thread 0 NONE -> commits in order CPU, loader, unloader on consecutive edges; ts_wr_rdy_ld rises 1 cycle before ts_wr_rdy_ul.
- Same-thread collision: CPU RD_RDY and loader WR_RDY both target thread 2 in the same cycle -> final ts_rd=WR_RDY.
- Back-pressure: loader asserts ts_wr_en_ld continuously for 4 distinct threads while the CPU writes every cycle -> no loader accept after the first; after the CPU stops, remaining writes complete at 1 per 2 cycles with no loss or duplication.
- Mid-operation reset: pulse RESET_N=0 for 1 cycle with both holding registers full -> held writes never commit; all entries return to NONE; init_done low for N_THREADS+1 cycles.
